// File: rtl/conv_dw_pkg.sv
// conv_dw_pkg: shared constants, FSM state type and packed-bus index helpers
// for the depthwise strided convolution block.
package conv_dw_pkg;

    // Cycles from the accepting edge of a window's bottom-right pixel to o_valid.
    localparam int PIPE_LAT = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } conv_state_e;

    // Number of output positions along one edge of the frame.
    function automatic int out_dim(input int if_size, input int k_size, input int stride);
        return (if_size - k_size) / stride + 1;
    endfunction

    // Number of results produced for one complete frame.
    function automatic int out_count(input int if_size, input int k_size, input int stride);
        return out_dim(if_size, k_size, stride) * out_dim(if_size, k_size, stride);
    endfunction

    // LSB of channel ch in a packed per-channel bus of element width bw.
    function automatic int px_lsb(input int ch, input int bw);
        return ch * bw;
    endfunction

    // LSB of weight (ky,kx) of channel ch; channel 0 and index ky*K+kx=0 sit at the LSB.
    function automatic int wt_lsb(input int ch, input int ky, input int kx,
                                  input int k_size, input int w_bw);
        return ((ch * k_size + ky) * k_size + kx) * w_bw;
    endfunction

endpackage

// File: rtl/dw_line_buf.sv
// dw_line_buf: K_SIZE-1 rows of raster-order pixel history for one channel.
// taps_o slice j holds the pixel j+1 rows above the pixel currently on pix_i.
module dw_line_buf #(
    parameter int I_BW    = 8,
    parameter int IF_SIZE = 28,
    parameter int K_SIZE  = 5
) (
    input  logic                         clk,
    input  logic                         global_rst_n,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic [I_BW-1:0]              pix_i,
    output logic [(K_SIZE-1)*I_BW-1:0]   taps_o
);

    localparam int DEPTH = (K_SIZE - 1) * IF_SIZE;

    // sr_q[i] holds the pixel accepted i+1 enables ago
    logic [I_BW-1:0] sr_q [DEPTH];

    // Shift the accepted pixel stream through the row history; frozen when en_i=0
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else if (en_i) begin
            sr_q[0] <= pix_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    for (genvar j = 0; j < K_SIZE - 1; j++) begin : g_tap
        assign taps_o[j*I_BW +: I_BW] = sr_q[(j+1)*IF_SIZE - 1];
    end

endmodule

// File: rtl/conv_dw_stride_nch.sv
// conv_dw_stride_nch: CH-channel depthwise KxK convolution over a streamed
// IF_SIZE x IF_SIZE frame with stride. Pipeline: window capture, MAC, output.
// Optional build macro CONV_DW_RELU_EN clamps negative channel results to 0.
//
// Handshake: i_valid qualifies i_fmap. A pixel is consumed on a rising edge
// where i_valid=1, the frame is open (o_busy=1) and the last pixel has not yet
// been taken. There is no backpressure; o_valid is a one-cycle qualifier for
// o_result, and o_result holds its value while o_valid=0.
module conv_dw_stride_nch
    import conv_dw_pkg::*;
#(
    parameter int CH      = 4,
    parameter int I_BW    = 8,
    parameter int W_BW    = 8,
    parameter int O_BW    = 20,
    parameter int IF_SIZE = 28,
    parameter int K_SIZE  = 5,
    parameter int STRIDE  = 1
) (
    input  logic                             clk,
    input  logic                             global_rst_n,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic                             i_valid,
    input  logic [CH*I_BW-1:0]               i_fmap,
    input  logic [CH*K_SIZE*K_SIZE*W_BW-1:0] i_weight,
    output logic [CH*O_BW-1:0]               o_result,
    output logic                             o_valid,
    output logic                             o_done,
    output logic                             o_busy
);

    localparam int CNT_W    = $clog2(IF_SIZE);
    localparam int WT_W     = CH * K_SIZE * K_SIZE * W_BW;
    // Bottom-right row/col of the final window emitted in a frame
    localparam int LAST_POS = K_SIZE - 1 + (out_dim(IF_SIZE, K_SIZE, STRIDE) - 1) * STRIDE;

    conv_state_e          state_q;
    logic [CNT_W-1:0]     col_q, row_q;
    logic                 in_done_q;
    logic [WT_W-1:0]      wt_q;
    logic [PIPE_LAT-2:0]  vld_q, last_q;
    logic                 out_vld_q, done_q;
    logic                 accept, win_hit, is_last, row_ok, col_ok, done_d;

    assign accept  = i_valid && (state_q == ST_RUN) && !in_done_q;
    assign row_ok  = (int'(row_q) >= K_SIZE - 1) && (((int'(row_q) - (K_SIZE - 1)) % STRIDE) == 0);
    assign col_ok  = (int'(col_q) >= K_SIZE - 1) && (((int'(col_q) - (K_SIZE - 1)) % STRIDE) == 0);
    assign win_hit = accept && row_ok && col_ok;
    assign is_last = (row_q == CNT_W'(LAST_POS)) && (col_q == CNT_W'(LAST_POS));
    assign done_d  = vld_q[PIPE_LAT-2] && last_q[PIPE_LAT-2];

    assign o_valid = out_vld_q;
    assign o_done  = done_q;
    assign o_busy  = (state_q == ST_RUN);

    // Frame FSM: latch weights on start, walk raster counters, close on final result
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            in_done_q <= 1'b0;
            wt_q      <= '0;
        end else if (rst) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            in_done_q <= 1'b0;
            wt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        wt_q      <= i_weight;
                        col_q     <= '0;
                        row_q     <= '0;
                        in_done_q <= 1'b0;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (done_d) state_q <= ST_IDLE;
                    if (accept) begin
                        if (col_q == CNT_W'(IF_SIZE - 1)) begin
                            col_q <= '0;
                            if (row_q == CNT_W'(IF_SIZE - 1)) in_done_q <= 1'b1;
                            else                              row_q     <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Valid/last tags advance every cycle so in-flight results drain without i_valid
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            vld_q     <= '0;
            last_q    <= '0;
            out_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (rst) begin
            vld_q     <= '0;
            last_q    <= '0;
            out_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            vld_q     <= {vld_q[PIPE_LAT-3:0], win_hit};
            last_q    <= {last_q[PIPE_LAT-3:0], win_hit && is_last};
            out_vld_q <= vld_q[PIPE_LAT-2];
            done_q    <= done_d;
        end
    end

    for (genvar ch = 0; ch < CH; ch++) begin : g_ch
        logic [(K_SIZE-1)*I_BW-1:0] taps;
        logic [I_BW-1:0]            win_q [K_SIZE][K_SIZE];
        logic signed [O_BW-1:0]     acc, px_ext, wt_ext;
        logic [O_BW-1:0]            sum_q, res_d, res_q;

        dw_line_buf #(
            .I_BW    (I_BW),
            .IF_SIZE (IF_SIZE),
            .K_SIZE  (K_SIZE)
        ) u_line_buf (
            .clk          (clk),
            .global_rst_n (global_rst_n),
            .clr_i        (rst),
            .en_i         (accept),
            .pix_i        (i_fmap[px_lsb(ch, I_BW) +: I_BW]),
            .taps_o       (taps)
        );

        // Slide the window one column left and load the new column (top row = oldest)
        always_ff @(posedge clk or negedge global_rst_n) begin
            if (!global_rst_n) begin
                for (int ky = 0; ky < K_SIZE; ky++)
                    for (int kx = 0; kx < K_SIZE; kx++) win_q[ky][kx] <= '0;
            end else if (rst) begin
                for (int ky = 0; ky < K_SIZE; ky++)
                    for (int kx = 0; kx < K_SIZE; kx++) win_q[ky][kx] <= '0;
            end else if (accept) begin
                for (int ky = 0; ky < K_SIZE; ky++)
                    for (int kx = 0; kx < K_SIZE - 1; kx++) win_q[ky][kx] <= win_q[ky][kx+1];
                for (int ky = 0; ky < K_SIZE - 1; ky++)
                    win_q[ky][K_SIZE-1] <= taps[(K_SIZE-2-ky)*I_BW +: I_BW];
                win_q[K_SIZE-1][K_SIZE-1] <= i_fmap[px_lsb(ch, I_BW) +: I_BW];
            end
        end

        // Window MAC; working in O_BW bits gives the wrap-around result directly
        always_comb begin
            acc    = '0;
            px_ext = '0;
            wt_ext = '0;
            for (int ky = 0; ky < K_SIZE; ky++) begin
                for (int kx = 0; kx < K_SIZE; kx++) begin
                    px_ext = O_BW'($signed({1'b0, win_q[ky][kx]}));
                    wt_ext = O_BW'($signed(wt_q[wt_lsb(ch, ky, kx, K_SIZE, W_BW) +: W_BW]));
                    acc    = acc + px_ext * wt_ext;
                end
            end
        end

`ifdef CONV_DW_RELU_EN
        assign res_d = sum_q[O_BW-1] ? '0 : sum_q;
`else
        assign res_d = sum_q;
`endif

        // MAC stage then output stage; output register only moves with a valid result
        always_ff @(posedge clk or negedge global_rst_n) begin
            if (!global_rst_n) begin
                sum_q <= '0;
                res_q <= '0;
            end else if (rst) begin
                sum_q <= '0;
                res_q <= '0;
            end else begin
                if (vld_q[0])          sum_q <= acc;
                if (vld_q[PIPE_LAT-2]) res_q <= res_d;
            end
        end

        assign o_result[px_lsb(ch, O_BW) +: O_BW] = res_q;
    end

endmodule
